// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes.
// One partial-product add per clock through a carry-lookahead adder.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b accepted in IDLE)
//   a, b                WIDTH-bit unsigned operands
//   out_valid/out_ready result handshake (product held until taken)
//   product             2*WIDTH-bit result register
//   busy                high while the multiply is running

module cla_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a flat sum of generate terms gated by the
  // propagate chain above them; carry-in is zero.
  always_comb begin
    logic v_cy;
    logic v_pp;
    w_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v_cy = 1'b0;
      v_pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        v_cy = v_cy | (v_pp & w_g[j]);
        v_pp = v_pp & w_p[j];
      end
      w_c[i+1] = v_cy;
    end
  end

  assign o_sum  = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_addend = r_acc[0] ? r_m : '0;

  cla_adder #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc[2*WIDTH-1:WIDTH]),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_RUN;
      S_RUN:  if (r_count == LAST) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RUN spends WIDTH cycles shifting, then one more cycle
  // copying the finished accumulator into the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_m     <= a;
      r_acc   <= {{WIDTH{1'b0}}, b};
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      if (r_count == LAST) begin
        r_product <= r_acc;
      end else begin
        r_acc   <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=8).
// Checks latency, handshakes, hold, reset abort and products.

module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Starts in IDLE; returns sampled in the first DONE cycle.
  task automatic do_op(input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic [15:0]  exp,
                       input string        tag,
                       input bit           hold);
    int lat;
    bit rdy_seen;
    chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (!hold) in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " product"}, 32'(product), 32'(exp));
    chk({tag, " ready_low"}, 32'(rdy_seen), 32'd0);
    chk({tag, " done_nbusy"}, 32'(busy), 32'd0);
  endtask

  task automatic consume(input logic [15:0] exp,
                         input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, " valid_fall"}, 32'(out_valid), 32'd0);
    chk({tag, " retain"}, 32'(product), 32'(exp));
    chk({tag, " back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("rst product", 32'(product), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    do_op(8'd13, 8'd11, 16'd143, "m13x11", 1'b0);
    consume(16'd143, "m13x11");

    do_op(8'd255, 8'd255, 16'hFE01, "m255x255", 1'b0);
    consume(16'hFE01, "m255x255");

    do_op(8'd0, 8'd200, 16'd0, "m0x200", 1'b0);
    consume(16'd0, "m0x200");

    do_op(8'd200, 8'd0, 16'd0, "m200x0", 1'b0);
    consume(16'd0, "m200x0");

    out_ready = 1'b0;
    do_op(8'd7, 8'd9, 16'd63, "m7x9", 1'b0);
    a = 8'd3;
    b = 8'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold valid", 32'(out_valid), 32'd1);
      chk("hold product", 32'(product), 32'd63);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    consume(16'd63, "m7x9");
    do_op(8'd3, 8'd4, 16'd12, "m3x4", 1'b0);
    consume(16'd12, "m3x4");

    a = 8'd100;
    b = 8'd100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort product", 32'(product), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("abort no_pulse", 32'(seen), 32'd0);
    do_op(8'd2, 8'd3, 16'd6, "m2x3", 1'b0);
    consume(16'd6, "m2x3");

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      do_op(ra, rb, 16'(ra) * 16'(rb),
            $sformatf("b2b%0d", i), 1'b1);
      consume(16'(ra) * 16'(rb),
              $sformatf("b2b%0d", i));
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
